// File: rtl/alu.sv
// Registered integer ALU using the MIPS R-type funct encodings.
// The datapath is combinational; the result and N/Z/C flags are captured one cycle later.
module alu #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [OP_WIDTH-1:0]   i_op,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_negative,
  output logic                  o_zero,
  output logic                  o_carry
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(6'b100000);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(6'b100010);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(6'b100100);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(6'b100101);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(6'b100110);
  localparam logic [OP_WIDTH-1:0] OP_NOR = OP_WIDTH'(6'b100111);
  localparam logic [OP_WIDTH-1:0] OP_SRA = OP_WIDTH'(6'b000011);
  localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(6'b000010);

  function automatic logic [DATA_WIDTH-1:0] shift_arith(
    input logic [DATA_WIDTH-1:0] value,
    input logic [SHAMT_W-1:0]    amount
  );
    logic signed [DATA_WIDTH-1:0] value_s;
    value_s = $signed(value);
    return DATA_WIDTH'(value_s >>> amount);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_logic(
    input logic [DATA_WIDTH-1:0] value,
    input logic [SHAMT_W-1:0]    amount
  );
    return value >> amount;
  endfunction

  logic [DATA_WIDTH:0]   sum_p0;
  logic [DATA_WIDTH-1:0] diff_p0;
  logic [SHAMT_W-1:0]    shamt_p0;
  logic [DATA_WIDTH-1:0] result_p0;
  logic                  negative_p0;
  logic                  carry_p0;
  logic                  zero_p0;

  logic [DATA_WIDTH-1:0] result_p1;
  logic                  negative_p1;
  logic                  zero_p1;
  logic                  carry_p1;

  // Stage p0: combinational operation decode and evaluation
  assign sum_p0   = {1'b0, i_a} + {1'b0, i_b};
  assign diff_p0  = i_a - i_b;
  assign shamt_p0 = i_b[SHAMT_W-1:0];

  always_comb begin
    result_p0   = '0;
    negative_p0 = 1'b0;
    carry_p0    = 1'b0;
    unique case (i_op)
      OP_ADD: begin
        result_p0 = sum_p0[DATA_WIDTH-1:0];
        carry_p0  = sum_p0[DATA_WIDTH];
      end
      OP_SUB: begin
        result_p0   = diff_p0;
        negative_p0 = diff_p0[DATA_WIDTH-1];
      end
      OP_AND: result_p0 = i_a & i_b;
      OP_OR:  result_p0 = i_a | i_b;
      OP_XOR: result_p0 = i_a ^ i_b;
      OP_NOR: result_p0 = ~(i_a | i_b);
      OP_SRA: begin
        result_p0   = shift_arith(i_a, shamt_p0);
        negative_p0 = result_p0[DATA_WIDTH-1];
      end
      OP_SRL: result_p0 = shift_logic(i_a, shamt_p0);
      default: result_p0 = '0;
    endcase
  end

  assign zero_p0 = (result_p0 == '0);

  // Stage p1: output registers; reset clears result and flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_p1   <= '0;
      negative_p1 <= 1'b0;
      zero_p1     <= 1'b0;
      carry_p1    <= 1'b0;
    end else begin
      result_p1   <= result_p0;
      negative_p1 <= negative_p0;
      zero_p1     <= zero_p0;
      carry_p1    <= carry_p0;
    end
  end

  assign o_result   = result_p1;
  assign o_negative = negative_p1;
  assign o_zero     = zero_p1;
  assign o_carry    = carry_p1;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset sequences and a
// randomised mix of operations checked against an independent reference model.
module tb_alu;

  localparam int DW = 8;
  localparam int OW = 6;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] a, b;
  logic [OW-1:0] op;
  logic [DW-1:0] result;
  logic          negative, zero, carry;

  int n_checks = 0;
  int n_fail   = 0;

  alu #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_a       (a),
    .i_b       (b),
    .i_op      (op),
    .o_result  (result),
    .o_negative(negative),
    .o_zero    (zero),
    .o_carry   (carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       n;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [5:0] o, logic [7:0] va, logic [7:0] vb,
                              logic [7:0] r, logic n, logic z, logic c);
    vec_t v;
    v.name = name; v.op = o; v.a = va; v.b = vb;
    v.r = r; v.n = n; v.z = z; v.c = c;
    return v;
  endfunction

  // Reference model built bit by bit, independent of the RTL's operators.
  function automatic logic [10:0] model(logic [5:0] o, logic [7:0] va, logic [7:0] vb);
    int         s;
    int         amt;
    logic [7:0] r;
    logic       n, c;
    r = 8'h00; n = 1'b0; c = 1'b0;
    amt = int'(vb[2:0]);
    case (o)
      ADD: begin s = int'(va) + int'(vb); r = s[7:0]; c = (s > 255); end
      SUB: begin s = int'(va) - int'(vb) + 256; r = s[7:0]; n = r[7]; end
      AND: for (int i = 0; i < 8; i++) r[i] = va[i] && vb[i];
      OR:  for (int i = 0; i < 8; i++) r[i] = va[i] || vb[i];
      XOR: for (int i = 0; i < 8; i++) r[i] = (va[i] != vb[i]);
      NOR: for (int i = 0; i < 8; i++) r[i] = !(va[i] || vb[i]);
      SRA: begin
        for (int i = 0; i < 8; i++) r[i] = (i + amt < 8) ? va[i + amt] : va[7];
        n = r[7];
      end
      SRL: for (int i = 0; i < 8; i++) r[i] = (i + amt < 8) ? va[i + amt] : 1'b0;
      default: r = 8'h00;
    endcase
    return {r, n, (r == 8'h00), c};
  endfunction

  task automatic check(string name, logic [10:0] got, logic [10:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got result=%02h N=%0b Z=%0b C=%0b, expected result=%02h N=%0b Z=%0b C=%0b",
               name, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1 time unit later.
  task automatic drive(logic r, logic [5:0] o, logic [7:0] va, logic [7:0] vb);
    @(negedge clk);
    rst = r; op = o; a = va; b = vb;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] outs();
    return {result, negative, zero, carry};
  endfunction

  initial begin
    rst = 1'b1; op = ADD; a = 8'd200; b = 8'd100;

    // Reset with a live ADD on the inputs, then release and hold the inputs.
    drive(1'b1, ADD, 8'd200, 8'd100);
    check("reset_state", outs(), {8'd0, 1'b0, 1'b0, 1'b0});
    drive(1'b0, ADD, 8'd200, 8'd100);
    check("first_after_reset", outs(), {8'd44, 1'b0, 1'b0, 1'b1});

    vecs.push_back(mk("add_wrap_zero", ADD, 8'd128, 8'd128, 8'h00, 0, 1, 1));
    vecs.push_back(mk("add_small",     ADD, 8'd3,   8'd4,   8'h07, 0, 0, 0));
    vecs.push_back(mk("add_ff_1",      ADD, 8'hFF,  8'h01,  8'h00, 0, 1, 1));
    vecs.push_back(mk("sub_negative",  SUB, 8'd5,   8'd10,  8'hFB, 1, 0, 0));
    vecs.push_back(mk("sub_equal",     SUB, 8'd77,  8'd77,  8'h00, 0, 1, 0));
    vecs.push_back(mk("sub_0_1",       SUB, 8'h00,  8'h01,  8'hFF, 1, 0, 0));
    vecs.push_back(mk("sub_pos",       SUB, 8'h30,  8'h10,  8'h20, 0, 0, 0));
    vecs.push_back(mk("sra_amt2",      SRA, 8'h90,  8'h0A,  8'hE4, 1, 0, 0));
    vecs.push_back(mk("srl_amt2",      SRL, 8'h90,  8'h0A,  8'h24, 0, 0, 0));
    vecs.push_back(mk("sra_amt0_wrap", SRA, 8'h90,  8'h08,  8'h90, 1, 0, 0));
    vecs.push_back(mk("sra_amt7",      SRA, 8'h80,  8'h07,  8'hFF, 1, 0, 0));
    vecs.push_back(mk("srl_amt7",      SRL, 8'h80,  8'h07,  8'h01, 0, 0, 0));
    vecs.push_back(mk("sra_pos_zero",  SRA, 8'h40,  8'h0F,  8'h00, 0, 1, 0));
    vecs.push_back(mk("srl_amt0",      SRL, 8'hFF,  8'h00,  8'hFF, 0, 0, 0));
    vecs.push_back(mk("and",           AND, 8'hF0,  8'h3C,  8'h30, 0, 0, 0));
    vecs.push_back(mk("or",            OR,  8'hF0,  8'h3C,  8'hFC, 0, 0, 0));
    vecs.push_back(mk("xor",           XOR, 8'hF0,  8'h3C,  8'hCC, 0, 0, 0));
    vecs.push_back(mk("xor_zero",      XOR, 8'hFF,  8'hFF,  8'h00, 0, 1, 0));
    vecs.push_back(mk("nor_zero",      NOR, 8'h0F,  8'hF0,  8'h00, 0, 1, 0));
    vecs.push_back(mk("nor_ones",      NOR, 8'h00,  8'h00,  8'hFF, 0, 0, 0));
    vecs.push_back(mk("invalid_3f",    6'b111111, 8'hFF, 8'hFF, 8'h00, 0, 1, 0));
    vecs.push_back(mk("invalid_00",    6'b000000, 8'h05, 8'h05, 8'h00, 0, 1, 0));
    vecs.push_back(mk("invalid_add_c", 6'b100001, 8'hFF, 8'hFF, 8'h00, 0, 1, 0));

    // Back-to-back: one new operation every cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, outs(), {vecs[i].r, vecs[i].n, vecs[i].z, vecs[i].c});
    end

    // Mid-stream reset overrides a flag-setting SUB, then normal loading resumes.
    drive(1'b0, SUB, 8'd5, 8'd10);
    check("pre_midreset", outs(), {8'hFB, 1'b1, 1'b0, 1'b0});
    drive(1'b1, ADD, 8'hFF, 8'hFF);
    check("midstream_reset", outs(), {8'd0, 1'b0, 1'b0, 1'b0});
    drive(1'b0, ADD, 8'hFF, 8'hFF);
    check("post_midreset", outs(), {8'hFE, 1'b0, 1'b0, 1'b1});

    // Output holds only for one cycle: a changed operation replaces it next edge.
    drive(1'b0, SRL, 8'hF0, 8'h04);
    check("seq_srl", outs(), {8'h0F, 1'b0, 1'b0, 1'b0});

    // Random mixed regression against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [5:0] ro;
      logic [7:0] ra, rb;
      case ($urandom_range(0, 8))
        0: ro = ADD; 1: ro = SUB; 2: ro = AND; 3: ro = OR; 4: ro = XOR;
        5: ro = NOR; 6: ro = SRA; 7: ro = SRL;
        default: ro = 6'($urandom_range(0, 63));
      endcase
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      drive(1'b0, ro, ra, rb);
      check($sformatf("rand%0d_op%02h_%02h_%02h", i, ro, ra, rb), outs(), model(ro, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
